// File: rtl/cart_loader.sv
// Cartridge loader: streams an HPS download into cartridge RAM while holding the CPU,
// and arbitrates single outstanding CPU reads against the same RAM port.
module cart_loader #(
    parameter logic [7:0] CART_INDEX  = 8'd1,
    parameter int         ADDR_W      = 15,
    parameter int         RELEASE_CYC = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_rd_data,
    output logic              cpu_ack,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic [ADDR_W:0]   cart_size,
    output logic              cart_valid,
    output logic              overflow
);

    localparam int CNT_W = $clog2(RELEASE_CYC + 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYC - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, LOADING, RELEASE} state_t;

    state_t           state;
    logic             dl_q;
    logic             rd_phase;
    logic [CNT_W-1:0] rel_cnt;

    logic             dl_start;
    logic             addr_ovf;
    logic [ADDR_W:0]  wr_end;

    assign dl_start = ioctl_download & ~dl_q & (ioctl_index == CART_INDEX);
    assign addr_ovf = |ioctl_addr[24:ADDR_W];
    assign wr_end   = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W + 1)'(1);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            // NOTE: dl_q resets high so a download still active across reset is not
            // mistaken for a fresh start; only a genuine 0->1 edge begins a load.
            dl_q        <= 1'b1;
            rd_phase    <= 1'b0;
            rel_cnt     <= '0;
            cpu_rd_data <= '0;
            cpu_ack     <= 1'b0;
            cpu_hold    <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_we      <= 1'b0;
            cart_size   <= '0;
            cart_valid  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            dl_q    <= ioctl_download;
            cpu_ack <= 1'b0;
            ram_we  <= 1'b0;

            if (dl_start) begin
                // A start preempts everything, including an in-flight read.
                state      <= LOADING;
                cpu_hold   <= 1'b1;
                cart_size  <= '0;
                cart_valid <= 1'b0;
                overflow   <= 1'b0;
                rd_phase   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cpu_req) begin
                            ram_addr <= cpu_addr;
                            rd_phase <= 1'b0;
                            state    <= RD_WAIT;
                        end
                    end

                    RD_WAIT: begin
                        // First cycle covers the RAM's registered read latency.
                        if (!rd_phase) begin
                            rd_phase <= 1'b1;
                        end else begin
                            cpu_rd_data <= ram_dout;
                            cpu_ack     <= 1'b1;
                            rd_phase    <= 1'b0;
                            state       <= IDLE;
                        end
                    end

                    LOADING: begin
                        if (ioctl_wr) begin
                            if (addr_ovf) begin
                                overflow <= 1'b1;
                            end else begin
                                ram_we   <= 1'b1;
                                ram_addr <= ioctl_addr[ADDR_W-1:0];
                                ram_din  <= ioctl_dout;
                                if (wr_end > cart_size) begin
                                    cart_size <= wr_end;
                                end
                            end
                        end
                        if (!ioctl_download) begin
                            rel_cnt <= '0;
                            state   <= RELEASE;
                        end
                    end

                    RELEASE: begin
                        if (rel_cnt == REL_LAST) begin
                            cpu_hold   <= 1'b0;
                            cart_valid <= (cart_size != '0);
                            state      <= IDLE;
                        end else begin
                            rel_cnt <= rel_cnt + CNT_W'(1);
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: reads, full load, overflow, foreign index,
// read/download collision and reset mid-load, against a small synchronous RAM model.
module tb_cart_loader;

    localparam int ADDR_W      = 15;
    localparam int RELEASE_CYC = 16;

    logic              clk_sys;
    logic              reset;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_rd_data;
    logic              cpu_ack;
    logic              cpu_hold;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic [7:0]        ram_dout;
    logic [ADDR_W:0]   cart_size;
    logic              cart_valid;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    cart_loader #(
        .CART_INDEX (8'd1),
        .ADDR_W     (ADDR_W),
        .RELEASE_CYC(RELEASE_CYC)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_rd_data   (cpu_rd_data),
        .cpu_ack       (cpu_ack),
        .cpu_hold      (cpu_hold),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_we        (ram_we),
        .ram_dout      (ram_dout),
        .cart_size     (cart_size),
        .cart_valid    (cart_valid),
        .overflow      (overflow)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Synchronous RAM model; reset preloads the byte used by the basic read.
    always @(posedge clk_sys) begin
        if (reset) begin
            mem[15'h0123] <= 8'h5A;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd_data"},    32'(cpu_rd_data), 32'h0);
        check({tag, ".ack"},        32'(cpu_ack),     32'h0);
        check({tag, ".hold"},       32'(cpu_hold),    32'h0);
        check({tag, ".ram_addr"},   32'(ram_addr),    32'h0);
        check({tag, ".ram_din"},    32'(ram_din),     32'h0);
        check({tag, ".ram_we"},     32'(ram_we),      32'h0);
        check({tag, ".cart_size"},  32'(cart_size),   32'h0);
        check({tag, ".cart_valid"}, 32'(cart_valid),  32'h0);
        check({tag, ".overflow"},   32'(overflow),    32'h0);
    endtask

    task automatic do_write(input logic [24:0] a, input logic [7:0] d, input logic dl_after);
        ioctl_wr       = 1'b1;
        ioctl_addr     = a;
        ioctl_dout     = d;
        ioctl_download = dl_after;
        tick();
        ioctl_wr = 1'b0;
    endtask

    logic [7:0] load_bytes [4];

    initial begin
        load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        cpu_req        = 1'b0;
        cpu_addr       = '0;

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Basic read: ack lands two edges after the request edge.
        cpu_req  = 1'b1;
        cpu_addr = 15'h0123;
        tick();
        cpu_req = 1'b0;
        check("rd.ram_addr", 32'(ram_addr), 32'h0123);
        check("rd.ack_e0",   32'(cpu_ack),  32'h0);
        tick();
        check("rd.ack_e1",   32'(cpu_ack),  32'h0);
        tick();
        check("rd.ack_e2",   32'(cpu_ack),     32'h1);
        check("rd.data",     32'(cpu_rd_data), 32'h5A);
        tick();
        check("rd.ack_low",  32'(cpu_ack),  32'h0);

        // Full load of four bytes; last write shares its cycle with download falling.
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick();
        check("ld.hold_start", 32'(cpu_hold),  32'h1);
        check("ld.size_clr",   32'(cart_size), 32'h0);
        for (int i = 0; i < 4; i++) begin
            do_write(25'(i), load_bytes[i], (i == 3) ? 1'b0 : 1'b1);
            check($sformatf("ld.we%0d", i),   32'(ram_we),   32'h1);
            check($sformatf("ld.addr%0d", i), 32'(ram_addr), 32'(i));
            check($sformatf("ld.din%0d", i),  32'(ram_din),  32'(load_bytes[i]));
            check($sformatf("ld.hold%0d", i), 32'(cpu_hold), 32'h1);
            if (i != 3) begin
                tick();
                check($sformatf("ld.we_low%0d", i), 32'(ram_we), 32'h0);
            end
        end
        check("ld.size", 32'(cart_size), 32'd4);
        for (int i = 1; i < RELEASE_CYC; i++) begin
            tick();
            check($sformatf("ld.rel_hold%0d", i), 32'(cpu_hold), 32'h1);
            check($sformatf("ld.rel_we%0d", i),   32'(ram_we),   32'h0);
        end
        check("ld.valid_pre", 32'(cart_valid), 32'h0);
        tick();
        check("ld.hold_end", 32'(cpu_hold),   32'h0);
        check("ld.valid",    32'(cart_valid), 32'h1);

        // Overflow: in-range byte at 5, then a dropped write at 0x8000.
        ioctl_download = 1'b1;
        tick();
        check("ov.valid_clr", 32'(cart_valid), 32'h0);
        check("ov.size_clr",  32'(cart_size),  32'h0);
        do_write(25'h5, 8'h66, 1'b1);
        check("ov.we_ok",   32'(ram_we),    32'h1);
        check("ov.size6",   32'(cart_size), 32'd6);
        tick();
        do_write(25'h8000, 8'h77, 1'b1);
        check("ov.we_drop", 32'(ram_we),    32'h0);
        check("ov.flag",    32'(overflow),  32'h1);
        check("ov.size",    32'(cart_size), 32'd6);
        ioctl_download = 1'b0;
        tick();
        for (int i = 0; i < RELEASE_CYC; i++) tick();
        check("ov.valid",      32'(cart_valid), 32'h1);
        check("ov.flag_stays", 32'(overflow),   32'h1);
        check("ov.hold_end",   32'(cpu_hold),   32'h0);

        // Foreign index: ignored; reads still served (byte 2 was loaded as 0x33).
        ioctl_index    = 8'd2;
        ioctl_download = 1'b1;
        tick();
        check("fx.hold", 32'(cpu_hold), 32'h0);
        do_write(25'h0, 8'hEE, 1'b1);
        check("fx.we",   32'(ram_we),   32'h0);
        cpu_req  = 1'b1;
        cpu_addr = 15'h0002;
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        check("fx.ack",  32'(cpu_ack),     32'h1);
        check("fx.data", 32'(cpu_rd_data), 32'h33);
        ioctl_download = 1'b0;
        ioctl_index    = 8'd1;
        tick();

        // Collision: download starts the cycle after the request; read abandoned.
        cpu_req  = 1'b1;
        cpu_addr = 15'h0123;
        tick();
        cpu_req        = 1'b0;
        ioctl_download = 1'b1;
        tick();
        check("co.hold",  32'(cpu_hold), 32'h1);
        check("co.ack1",  32'(cpu_ack),  32'h0);
        tick();
        check("co.ack2",  32'(cpu_ack),  32'h0);
        do_write(25'h10, 8'hA1, 1'b1);
        check("co.we",    32'(ram_we),   32'h1);
        check("co.addr",  32'(ram_addr), 32'h10);

        // Reset after the second write of the load.
        do_write(25'h11, 8'hA2, 1'b1);
        check("rs.we2", 32'(ram_we), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rs.async");
        tick();
        reset = 1'b0;
        tick();
        do_write(25'h12, 8'hA3, 1'b1);
        check("rs.we_after",   32'(ram_we),   32'h0);
        check("rs.hold_after", 32'(cpu_hold), 32'h0);
        ioctl_download = 1'b0;
        for (int i = 0; i < RELEASE_CYC + 2; i++) tick();
        check("rs.valid",      32'(cart_valid), 32'h0);
        check("rs.hold_final", 32'(cpu_hold),   32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
